// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin grant arbiter.
package arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First set request bit strictly after 'last', wrapping; 'last' itself is checked last.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req_vec,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] cand;
    rr_pick = last;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last + IDX_W'(k);
      if (req_vec[cand]) rr_pick = cand;
    end
  endfunction

endpackage

// File: rtl/decoder_2to4.sv
// 2-to-4 one-hot decoder with enable; output is all zero when disabled.
module decoder_2to4 (
  input  logic [1:0] idx,
  input  logic       en,
  output logic [3:0] dec
);

  always_comb begin
    dec = 4'b0000;
    if (en) dec = 4'b0001 << idx;
  end

endmodule

// File: rtl/grant_arbiter_4.sv
// Round-robin arbiter for 4 requesters with one idle cycle between grants.
// Define ARB_TIMEOUT_EN to revoke a grant after HOLD_MAX cycles and pulse timeout.
module grant_arbiter_4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               timeout
);

  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_hold_range_bad
    $error("grant_arbiter_4: HOLD_MAX must be in 2..255");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             release_now;

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             expire;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    release_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
    expire      = (state_q == GRANT) && (cnt_q == CNT_W'(HOLD_MAX - 1));
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          idx_d   = rr_pick(req, idx_q);
        end
      end
      GRANT: begin
        release_now = done || !req[idx_q];
`ifdef ARB_TIMEOUT_EN
        release_now = release_now || expire;
`endif
        if (release_now) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef ARB_TIMEOUT_EN
    // A normal release on the expiry cycle takes precedence, so no timeout pulse.
    timeout_d = expire && !done && req[idx_q];
    cnt_d     = ((state_q == GRANT) && !release_now) ? cnt_q + CNT_W'(1) : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = idx_q;

  decoder_2to4 u_dec (
    .idx (idx_q),
    .en  (gnt_valid),
    .dec (gnt)
  );

endmodule

// File: tb/tb_grant_arbiter_4.sv
// Directed bench for grant_arbiter_4 with a per-cycle reference model and literal checkpoints.
module tb_grant_arbiter_4;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic       timeout;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  grant_arbiter_4 #(.HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who holds the grant, how long it has been held, who was served last.
  int holder = -1;
  int last   = 3;
  int held   = 0;
  bit m_tmo  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holder = -1;
      last   = 3;
      held   = 0;
      m_tmo  = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (holder < 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (holder < 0 && req[(last + k) % 4]) begin
            holder = (last + k) % 4;
          end
        end
        if (holder >= 0) begin
          last = holder;
          held = 1;
        end
      end else if (done || !req[holder]) begin
        holder = -1;
      end else if (TMO_ON && held == HOLD) begin
        holder = -1;
        m_tmo  = 1'b1;
      end else begin
        held++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_gnt", {28'd0, gnt}, (holder >= 0) ? (32'd1 << holder) : 32'd0);
      check("model_gnt_valid", {31'd0, gnt_valid}, {31'd0, holder >= 0});
      check("model_gnt_idx", {30'd0, gnt_idx}, last);
      check("model_timeout", {31'd0, timeout}, {31'd0, m_tmo});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  int seq [5] = '{0, 1, 2, 3, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) at_neg();
    check("rst_gnt", {28'd0, gnt}, 32'd0);
    check("rst_gnt_idx", {30'd0, gnt_idx}, 32'd3);
    check("rst_valid", {31'd0, gnt_valid}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();
    tick();
    at_neg();
    check("idle_no_req", {28'd0, gnt}, 32'd0);

    // Full round-robin with done pulsed each grant
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      at_neg();
      check("rr_grant", {28'd0, gnt}, 32'd1 << seq[g]);
      done = 1'b1;
      tick();
      done = 1'b0;
      at_neg();
      check("rr_gap", {28'd0, gnt}, 32'd0);
    end
    req = 4'b0000;
    tick();

    // Grant 2, drop it, then 0011 must wrap to requester 0
    req = 4'b0100;
    tick();
    at_neg();
    check("g2_gnt", {28'd0, gnt}, 32'h4);
    req = 4'b0011;
    tick();
    at_neg();
    check("g2_released", {28'd0, gnt}, 32'd0);
    check("g2_idx_held", {30'd0, gnt_idx}, 32'd2);
    tick();
    at_neg();
    check("wrap_gnt", {28'd0, gnt}, 32'h1);
    req = 4'b0000;
    tick();

    // Single-cycle request
    tick();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    at_neg();
    check("pulse_gnt", {28'd0, gnt}, 32'h4);
    tick();
    at_neg();
    check("pulse_drop", {28'd0, gnt}, 32'd0);

    // Other requesters toggling must not disturb the holder
    req = 4'b0010;
    tick();
    req = 4'b1010;
    tick();
    req = 4'b0011;
    tick();
    at_neg();
    check("stable_gnt", {28'd0, gnt}, 32'h2);
    req = 4'b0000;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    at_neg();
    check("done_in_idle", {28'd0, gnt}, 32'd0);

`ifdef ARB_TIMEOUT_EN
    // Hold limit revokes and regrants
    req = 4'b0010;
    tick();
    for (int i = 0; i < HOLD; i++) begin
      at_neg();
      check("hold_gnt", {28'd0, gnt}, 32'h2);
      tick();
    end
    at_neg();
    check("expire_gnt", {28'd0, gnt}, 32'd0);
    check("expire_timeout", {31'd0, timeout}, 32'd1);
    tick();
    at_neg();
    check("regrant_gnt", {28'd0, gnt}, 32'h2);
    check("regrant_timeout", {31'd0, timeout}, 32'd0);
    tick();
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    at_neg();
    check("done_at_expiry_gnt", {28'd0, gnt}, 32'd0);
    check("done_at_expiry_timeout", {31'd0, timeout}, 32'd0);
    req = 4'b0000;
    tick();
`else
    // Without the hold limit a grant persists
    req = 4'b0010;
    repeat (12) tick();
    at_neg();
    check("long_hold_gnt", {28'd0, gnt}, 32'h2);
    check("long_hold_timeout", {31'd0, timeout}, 32'd0);
    req = 4'b0000;
    tick();
    tick();
`endif

    // Asynchronous reset during a grant
    req = 4'b0001;
    tick();
    at_neg();
    check("pre_rst_gnt", {28'd0, gnt}, 32'h1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_gnt", {28'd0, gnt}, 32'd0);
    check("async_rst_valid", {31'd0, gnt_valid}, 32'd0);
    check("async_rst_idx", {30'd0, gnt_idx}, 32'd3);
    req = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    req = 4'b1000;
    tick();
    at_neg();
    check("post_rst_gnt3", {28'd0, gnt}, 32'h8);
    check("post_rst_idx3", {30'd0, gnt_idx}, 32'd3);
    req = 4'b0000;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
